// File: rtl/load_filter_unit.sv
// load_filter_unit
// ----------------
// Memory-stage load engine. It issues a single word read to data memory and
// waits for the ack handshake. It then extracts the addressed byte, halfword
// or word from the returned word and sign- or zero-extends it. The registered
// result feeds the LUI/extend select mux. o_busy stalls the pipeline while a
// read is outstanding. A timeout counter bounds every read.
//
// Handshake: o_mem_rd_en rises in the cycle after i_start is accepted. It
// stays high, with o_mem_addr stable, until a cycle in which i_mem_ack=1. In
// that cycle i_mem_rdata is captured. i_mem_ack is ignored in any other cycle.
//
// Optional feature (macro LOAD_ALIGN_CHECK_EN): misaligned half/word requests
// are rejected in IDLE with a one-cycle o_misaligned pulse and no read.
// Without the macro, o_misaligned is constant 0 and the low address bits that
// the access size does not use are ignored.
//
// Ports:
//   i_clk, i_reset      clock (rising edge), async active-high reset
//   i_start             load request pulse, sampled only in IDLE
//   i_addr              byte address of the load
//   i_size              00 byte, 01 half, 10 word, 11 reserved (word)
//   i_unsigned          1 = zero-extend, 0 = sign-extend
//   o_mem_rd_en         read strobe, held until ack
//   o_mem_addr          registered word-aligned address
//   i_mem_rdata         read word, valid with i_mem_ack
//   i_mem_ack           memory completion strobe
//   o_filter_load       registered filtered/extended load data
//   o_valid             one-cycle pulse when o_filter_load updates
//   o_busy              pipeline stall request
//   o_bus_error         one-cycle pulse on timeout
//   o_misaligned        one-cycle pulse on a rejected misaligned request
//   o_dbg_state         current FSM state (0 IDLE, 1 REQ, 2 DONE)
module load_filter_unit #(
   parameter int NBITS          = 32,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [NBITS-1:0] i_addr,
   input  logic [1:0]       i_size,
   input  logic             i_unsigned,
   output logic             o_mem_rd_en,
   output logic [NBITS-1:0] o_mem_addr,
   input  logic [NBITS-1:0] i_mem_rdata,
   input  logic             i_mem_ack,
   output logic [NBITS-1:0] o_filter_load,
   output logic             o_valid,
   output logic             o_busy,
   output logic             o_bus_error,
   output logic             o_misaligned,
   output logic [1:0]       o_dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // The counter runs 0..TIMEOUT_CYCLES-1 while in REQ. The read aborts in
   // the REQ cycle where the counter sits at the limit and no ack arrives.
   localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

   state_t           state, state_nxt;
   logic [7:0]       cnt;
   logic [1:0]       size_q;
   logic             unsigned_q;
   logic [1:0]       off_q;
   logic             misalign;
   logic             err_pulse;
   logic             mis_pulse;
   logic [NBITS-1:0] filt;
   logic [7:0]       lane_b;
   logic [15:0]      lane_h;

`ifdef LOAD_ALIGN_CHECK_EN
   always_comb begin
      misalign = 1'b0;
      if (i_size == 2'b01)
         misalign = i_addr[0];
      else if (i_size[1])
         misalign = (i_addr[1:0] != 2'b00);
   end
`else
   assign misalign = 1'b0;
`endif

   // State register
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (i_start && !misalign) state_nxt = ST_REQ;
         ST_REQ: begin
            // Ack wins over a timeout that falls in the same cycle.
            if (i_mem_ack)
               state_nxt = ST_DONE;
            else if (cnt == CNT_LIMIT)
               state_nxt = ST_IDLE;
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Outputs that follow the state directly. Because the state register
   // resets asynchronously, these outputs drop as soon as reset asserts.
   always_comb begin
      o_mem_rd_en = 1'b0;
      o_busy      = 1'b0;
      o_valid     = 1'b0;
      case (state)
         ST_REQ: begin
            o_mem_rd_en = 1'b1;
            o_busy      = 1'b1;
         end
         ST_DONE: o_valid = 1'b1;
         default: ;
      endcase
   end

   assign o_bus_error  = err_pulse;
   assign o_misaligned = mis_pulse;
   assign o_dbg_state  = state;

   // Little-endian lane extraction from the latched offset.
   always_comb begin
      lane_b = 8'h00;
      case (off_q)
         2'd0: lane_b = i_mem_rdata[7:0];
         2'd1: lane_b = i_mem_rdata[15:8];
         2'd2: lane_b = i_mem_rdata[23:16];
         2'd3: lane_b = i_mem_rdata[31:24];
         default: lane_b = i_mem_rdata[7:0];
      endcase
      lane_h = off_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
      case (size_q)
         2'b00:   filt = {{(NBITS-8){~unsigned_q & lane_b[7]}}, lane_b};
         2'b01:   filt = {{(NBITS-16){~unsigned_q & lane_h[15]}}, lane_h};
         default: filt = i_mem_rdata;
      endcase
   end

   // Datapath registers: request fields, counter, result and status pulses.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         cnt           <= '0;
         size_q        <= '0;
         unsigned_q    <= 1'b0;
         off_q         <= '0;
         o_mem_addr    <= '0;
         o_filter_load <= '0;
         err_pulse     <= 1'b0;
         mis_pulse     <= 1'b0;
      end else begin
         err_pulse <= 1'b0;
         mis_pulse <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_start && misalign) begin
                  mis_pulse <= 1'b1;
               end else if (i_start) begin
                  size_q     <= i_size;
                  unsigned_q <= i_unsigned;
                  off_q      <= i_addr[1:0];
                  o_mem_addr <= {i_addr[NBITS-1:2], 2'b00};
                  cnt        <= '0;
               end
            end
            ST_REQ: begin
               if (i_mem_ack)
                  o_filter_load <= filt;
               else if (cnt == CNT_LIMIT)
                  err_pulse <= 1'b1;
               else
                  cnt <= cnt + 8'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_filter_unit.sv
// Directed testbench for load_filter_unit, built with TIMEOUT_CYCLES=4.
// Inputs are driven on the falling edge and outputs are sampled on the
// falling edge, half a cycle away from the active rising edge.
module tb_load_filter_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] addr = '0;
   logic [1:0]   size = '0;
   logic         uns = 1'b0;
   logic         rd_en;
   logic [W-1:0] mem_addr;
   logic [W-1:0] rdata = '0;
   logic         ack = 1'b0;
   logic [W-1:0] filter_load;
   logic         valid;
   logic         busy;
   logic         bus_error;
   logic         misaligned;
   logic [1:0]   dbg_state;

   int tests_run = 0;
   int tests_failed = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] last_load = '0;

   load_filter_unit #(.NBITS(W), .TIMEOUT_CYCLES(4)) dut (
      .i_clk(clk), .i_reset(rst), .i_start(start), .i_addr(addr),
      .i_size(size), .i_unsigned(uns), .o_mem_rd_en(rd_en),
      .o_mem_addr(mem_addr), .i_mem_rdata(rdata), .i_mem_ack(ack),
      .o_filter_load(filter_load), .o_valid(valid), .o_busy(busy),
      .o_bus_error(bus_error), .o_misaligned(misaligned),
      .o_dbg_state(dbg_state)
   );

   // Clock / reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got,
                        input logic [W-1:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Present a one-cycle start pulse; returns at the negedge after the edge
   // that sampled it.
   task automatic pulse_start(input logic [W-1:0] a, input logic [1:0] s,
                              input logic u);
      @(negedge clk);
      start = 1'b1; addr = a; size = s; uns = u;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Full load: ack arrives on REQ cycle number dly (1 = first REQ cycle).
   task automatic do_load(input string tag, input logic [W-1:0] a,
                          input logic [1:0] s, input logic u,
                          input logic [W-1:0] rd, input int dly,
                          input logic [W-1:0] exp_val);
      int rd_cnt;
      logic [W-1:0] exp;
      rd_cnt = 0;
      exp_q.push_back(exp_val);
      pulse_start(a, s, u);
      check({tag, "_mem_addr"}, mem_addr, {a[W-1:2], 2'b00});
      for (int k = 1; k <= dly; k++) begin
         if (rd_en) rd_cnt++;
         check({tag, "_busy_req"}, {31'd0, busy}, 32'd1);
         if (k == dly) begin ack = 1'b1; rdata = rd; end
         @(negedge clk);
         ack = 1'b0;
         rdata = 32'h5A5A_5A5A;
      end
      check({tag, "_rd_en_cycles"}, rd_cnt, dly);
      check({tag, "_valid"}, {31'd0, valid}, 32'd1);
      check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
      check({tag, "_no_err"}, {31'd0, bus_error}, 32'd0);
      exp = exp_q.pop_front();
      check({tag, "_data"}, filter_load, exp);
      last_load = exp;
      // A start seen in DONE must not launch a new read.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_valid_once"}, {31'd0, valid}, 32'd0);
      check({tag, "_start_in_done_ignored"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      #3;
      check("reset_rd_en", {31'd0, rd_en}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_valid", {31'd0, valid}, 32'd0);
      check("reset_load", filter_load, 32'd0);
      check("reset_mem_addr", mem_addr, 32'd0);
      check("reset_err", {31'd0, bus_error | misaligned}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Ack in IDLE is ignored.
      ack = 1'b1; rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      ack = 1'b0;
      check("idle_ack_valid", {31'd0, valid}, 32'd0);
      check("idle_ack_load", filter_load, 32'd0);

      do_load("sbyte",  32'h0000_1003, 2'b00, 1'b0, 32'h80FF_1234, 1, 32'hFFFF_FF80);
      do_load("uhalf",  32'h0000_2002, 2'b01, 1'b1, 32'hBEEF_0000, 1, 32'h0000_BEEF);
      do_load("ubyte1", 32'h0000_0005, 2'b00, 1'b1, 32'h0000_80FF, 2, 32'h0000_0080);
      do_load("sbyte0", 32'h0000_0010, 2'b00, 1'b0, 32'h1234_567F, 1, 32'h0000_007F);
      do_load("shalf0", 32'h0000_0020, 2'b01, 1'b0, 32'h1234_8001, 1, 32'hFFFF_8001);
      do_load("rsvd",   32'h0000_0030, 2'b11, 1'b1, 32'h8000_0000, 1, 32'h8000_0000);
      do_load("word3",  32'h0000_4000, 2'b10, 1'b0, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF);
      // Ack on the last allowed REQ cycle: ack wins over timeout.
      do_load("ack_at_limit", 32'h0000_5004, 2'b10, 1'b0, 32'h0BAD_F00D, 4, 32'h0BAD_F00D);

      // Timeout: no ack, four REQ cycles, then a bus_error pulse in IDLE.
      begin
         int rd_cnt;
         bit seen;
         rd_cnt = 0;
         seen = 1'b0;
         pulse_start(32'h0000_6000, 2'b10, 1'b0);
         for (int k = 0; k < 10 && !seen; k++) begin
            if (bus_error) seen = 1'b1;
            else begin
               if (rd_en) rd_cnt++;
               @(negedge clk);
            end
         end
         check("timeout_err_seen", {31'd0, seen}, 32'd1);
         check("timeout_req_cycles", rd_cnt, 4);
         check("timeout_busy", {31'd0, busy}, 32'd0);
         check("timeout_valid", {31'd0, valid}, 32'd0);
         check("timeout_load_hold", filter_load, last_load);
         @(negedge clk);
         check("timeout_err_pulse", {31'd0, bus_error}, 32'd0);
      end

      // Reset during REQ, then a late ack.
      pulse_start(32'h0000_7008, 2'b10, 1'b0);
      check("rst_mid_pre_busy", {31'd0, busy}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_rd_en", {31'd0, rd_en}, 32'd0);
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_load", filter_load, 32'd0);
      check("rst_mid_mem_addr", mem_addr, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      ack = 1'b1; rdata = 32'h1111_2222;
      @(negedge clk);
      ack = 1'b0;
      check("rst_mid_late_ack_valid", {31'd0, valid}, 32'd0);
      @(negedge clk);
      check("rst_mid_late_ack_valid2", {31'd0, valid}, 32'd0);
      check("rst_mid_late_ack_load", filter_load, 32'd0);
      last_load = '0;

      // Misaligned half at address 1.
`ifdef LOAD_ALIGN_CHECK_EN
      pulse_start(32'h0000_0001, 2'b01, 1'b0);
      check("mis_pulse", {31'd0, misaligned}, 32'd1);
      check("mis_rd_en", {31'd0, rd_en}, 32'd0);
      check("mis_busy", {31'd0, busy}, 32'd0);
      check("mis_load", filter_load, last_load);
      @(negedge clk);
      check("mis_pulse_once", {31'd0, misaligned}, 32'd0);
      check("mis_rd_en_after", {31'd0, rd_en}, 32'd0);
`else
      do_load("mis_half_nomacro", 32'h0000_0001, 2'b01, 1'b0, 32'h7777_8001, 1, 32'hFFFF_8001);
      check("mis_const0", {31'd0, misaligned}, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Watchdog: the directed sequence is short, so this only fires on a hang.
   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      tests_failed++;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $fatal(1, "watchdog");
   end

endmodule
